regfile_writeback: RTL and testbench

Writer side of the integer register file. It merges results from the single-cycle ALU path and the variable-latency load path onto the regfile's single write port (address_w/data_w, where address 0 means no write). It buffers ALU results while a load holds the port. It also gives decode a hazard query, so decode does not read a register whose write is still in flight.

---
 rtl/rv_pkg.sv | 13 +
 rtl/wb_fifo.sv | 81 ++++++++
 rtl/regfile_writeback.sv | 92 +++++++++
 tb/tb_regfile_writeback.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared register-file types for the integer writeback path.
package rv_pkg;
  localparam int REG_W  = 32;
  localparam int REG_N  = 32;
  localparam int REG_AW = $clog2(REG_N);

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t        rd;
    logic [REG_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of {rd, data} ALU results waiting for the regfile write port.
// Exposes every slot's rd with a valid bit so the top can run the hazard compare.
module wb_fifo
  import rv_pkg::*;
#(
  parameter int AW    = REG_AW,
  parameter int WIDTH = REG_W,
  parameter int DEPTH = 2,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                push,
  input  logic [AW-1:0]       push_rd,
  input  logic [WIDTH-1:0]    push_data,
  input  logic                pop,
  output logic                full,
  output logic                empty,
  output logic [AW-1:0]       head_rd,
  output logic [WIDTH-1:0]    head_data,
  output logic [DEPTH*AW-1:0] entry_rd,
  output logic [DEPTH-1:0]    entry_valid
);

  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);
  localparam logic [PW:0]   CNT_MAX = (PW + 1)'(DEPTH);

  logic [AW-1:0]    rd_mem   [DEPTH];
  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == CNT_MAX);
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_rd   = rd_mem[head];
  assign head_data = data_mem[head];

  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        rd_mem[tail]   <= push_rd;
        data_mem[tail] <= push_data;
        tail           <= tail + PTR_ONE;
      end
      if (do_pop) begin
        head <= head + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // A slot is live when its distance from head (mod DEPTH) is below count.
  always_comb begin
    logic [PW-1:0] off;
    off         = '0;
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off            = PW'(i) - head;
      entry_valid[i] = ({1'b0, off} < count);
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_rd
    assign entry_rd[g*AW +: AW] = rd_mem[g];
  end

endmodule

// File: rtl/regfile_writeback.sv
// Merges ALU and load results onto the regfile's single write port (address 0 = no write)
// and answers decode's "is this register still being written" query.
module regfile_writeback
  import rv_pkg::*;
#(
  parameter int WIDTH = REG_W,
  parameter int NUM   = REG_N,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(NUM)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [AW-1:0]    alu_rd,
  input  logic [WIDTH-1:0] alu_data,
  input  logic             mem_valid,
  input  logic [AW-1:0]    mem_rd,
  input  logic [WIDTH-1:0] mem_data,
  output logic [AW-1:0]    address_w,
  output logic [WIDTH-1:0] data_w,
  input  logic [AW-1:0]    chk_addr,
  output logic             chk_hit,
  output logic             busy
);

  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_push;
  logic                fifo_pop;
  logic [AW-1:0]       head_rd;
  logic [WIDTH-1:0]    head_data;
  logic [DEPTH*AW-1:0] entry_rd;
  logic [DEPTH-1:0]    entry_valid;
  logic                mem_take;
  logic                fifo_hit;

  assign alu_ready = !fifo_full;
  assign fifo_push = alu_valid && alu_ready && (alu_rd != '0);
  assign mem_take  = mem_valid && (mem_rd != '0);
  assign fifo_pop  = !mem_take && !fifo_empty;

  wb_fifo #(
    .AW    (AW),
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push        (fifo_push),
    .push_rd     (alu_rd),
    .push_data   (alu_data),
    .pop         (fifo_pop),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .head_rd     (head_rd),
    .head_data   (head_data),
    .entry_rd    (entry_rd),
    .entry_valid (entry_valid)
  );

  // Loads always win the port; buffered ALU results wait.
  always_ff @(posedge clock) begin
    if (reset) begin
      address_w <= '0;
      data_w    <= '0;
    end else if (mem_take) begin
      address_w <= mem_rd;
      data_w    <= mem_data;
    end else if (!fifo_empty) begin
      address_w <= head_rd;
      data_w    <= head_data;
    end else begin
      address_w <= '0;
      data_w    <= '0;
    end
  end

  always_comb begin
    fifo_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (entry_rd[i*AW +: AW] == chk_addr)) begin
        fifo_hit = 1'b1;
      end
    end
  end

  // address_w counts as pending: the regfile only absorbs it at the next edge.
  assign chk_hit = (chk_addr != '0) && ((address_w == chk_addr) || fifo_hit);
  assign busy    = !fifo_empty || (address_w != '0);

endmodule

// File: tb/tb_regfile_writeback.sv
// Randomised and directed bench for regfile_writeback against a queue-based model.
module tb_regfile_writeback;
  localparam int WIDTH = 32;
  localparam int NUM   = 32;
  localparam int DEPTH = 2;
  localparam int AW    = $clog2(NUM);

  logic             clock;
  logic             reset;
  logic             alu_valid;
  logic             alu_ready;
  logic [AW-1:0]    alu_rd;
  logic [WIDTH-1:0] alu_data;
  logic             mem_valid;
  logic [AW-1:0]    mem_rd;
  logic [WIDTH-1:0] mem_data;
  logic [AW-1:0]    address_w;
  logic [WIDTH-1:0] data_w;
  logic [AW-1:0]    chk_addr;
  logic             chk_hit;
  logic             busy;

  int tests = 0;
  int fails = 0;

  regfile_writeback #(.WIDTH(WIDTH), .NUM(NUM), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .address_w (address_w),
    .data_w    (data_w),
    .chk_addr  (chk_addr),
    .chk_hit   (chk_hit),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pending ALU results as a queue plus the visible write port.
  typedef struct packed {
    logic [AW-1:0]    rd;
    logic [WIDTH-1:0] data;
  } ent_t;

  ent_t             mq[$];
  logic [AW-1:0]    m_aw;
  logic [WIDTH-1:0] m_dw;
  bit               model_ok = 0;

  always @(posedge clock) begin
    bit room;
    ent_t e;
    if (reset) begin
      mq.delete();
      m_aw     = '0;
      m_dw     = '0;
      model_ok = 1;
    end else begin
      room = (mq.size() != DEPTH);
      if (mem_valid && mem_rd != '0) begin
        m_aw = mem_rd;
        m_dw = mem_data;
      end else if (mq.size() != 0) begin
        e    = mq.pop_front();
        m_aw = e.rd;
        m_dw = e.data;
      end else begin
        m_aw = '0;
        m_dw = '0;
      end
      if (alu_valid && room && alu_rd != '0) begin
        e.rd   = alu_rd;
        e.data = alu_data;
        mq.push_back(e);
      end
    end
  end

  always @(negedge clock) begin
    bit hit;
    if (model_ok) begin
      hit = (m_aw == chk_addr);
      foreach (mq[i]) if (mq[i].rd == chk_addr) hit = 1;
      if (chk_addr == '0) hit = 0;
      check("m_address_w", 64'(address_w), 64'(m_aw));
      check("m_data_w",    64'(data_w),    64'(m_dw));
      check("m_alu_ready", 64'(alu_ready), 64'(mq.size() != DEPTH));
      check("m_busy",      64'(busy),      64'((mq.size() != 0) || (m_aw != '0)));
      check("m_chk_hit",   64'(chk_hit),   64'(hit));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    mem_valid = 0; mem_rd = '0; mem_data = '0;
  endtask

  initial begin
    logic [AW-1:0]    obs_rd[$];
    logic [WIDTH-1:0] obs_d[$];
    int               exp_rd[7];
    int               exp_d[7];
    int               alu_i;
    bit               acc;

    exp_rd = '{7, 7, 7, 7, 1, 2, 3};
    exp_d  = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'h10, 32'h11, 32'h12};

    // Reset with both paths active must leave the port idle.
    reset = 1; chk_addr = '0;
    alu_valid = 1; alu_rd = 5; alu_data = 32'h55;
    mem_valid = 1; mem_rd = 5; mem_data = 32'h66;
    tick(); tick();
    reset = 0; idle_inputs();
    check("rst_address_w", 64'(address_w), 0);
    check("rst_data_w",    64'(data_w),    0);
    check("rst_busy",      64'(busy),      0);
    check("rst_alu_ready", 64'(alu_ready), 1);

    // Single ALU result.
    chk_addr = 3;
    alu_valid = 1; alu_rd = 3; alu_data = 32'h11;
    #1 check("single_ready", 64'(alu_ready), 1);
    tick();
    alu_valid = 0;
    check("single_e0_aw",  64'(address_w), 0);
    check("single_e0_hit", 64'(chk_hit),   1);
    tick();
    check("single_e1_aw",  64'(address_w), 3);
    check("single_e1_dw",  64'(data_w),    32'h11);
    check("single_e1_hit", 64'(chk_hit),   1);
    tick();
    check("single_e2_aw",  64'(address_w), 0);
    check("single_e2_hit", 64'(chk_hit),   0);

    // Loads starve the buffer; ALU results drain afterwards in order.
    chk_addr = '0;
    alu_i = 0;
    for (int c = 0; c < 10; c++) begin
      mem_valid = (c < 4); mem_rd = 7; mem_data = 32'hA0 + WIDTH'(c);
      alu_valid = (alu_i < 3); alu_rd = AW'(alu_i + 1); alu_data = 32'h10 + WIDTH'(alu_i);
      #1;
      acc = alu_valid && alu_ready;
      if (c == 2) check("starve_full", 64'(alu_ready), 0);
      tick();
      if (acc) alu_i++;
      if (address_w != '0) begin
        obs_rd.push_back(address_w);
        obs_d.push_back(data_w);
      end
    end
    idle_inputs();
    check("starve_count", 64'(obs_rd.size()), 7);
    for (int i = 0; i < 7 && i < obs_rd.size(); i++) begin
      check("starve_rd",   64'(obs_rd[i]), 64'(exp_rd[i]));
      check("starve_data", 64'(obs_d[i]),  64'(exp_d[i]));
    end

    // Zero-register ALU result and zero-register load.
    alu_valid = 1; alu_rd = 0; alu_data = 32'hFF;
    #1 check("zero_alu_ready", 64'(alu_ready), 1);
    tick();
    alu_rd = 4; alu_data = 32'h44;
    check("zero_alu_aw",   64'(address_w), 0);
    check("zero_alu_busy", 64'(busy),      0);
    tick();
    alu_valid = 0;
    mem_valid = 1; mem_rd = 0; mem_data = 32'h99;
    tick();
    idle_inputs();
    check("zero_mem_aw", 64'(address_w), 4);
    check("zero_mem_dw", 64'(data_w),    32'h44);
    tick();

    // Back-to-back ALU results wrap the pointers.
    for (int i = 1; i <= 6; i++) begin
      alu_valid = 1; alu_rd = AW'(i); alu_data = 32'h100 + WIDTH'(i);
      #1 check("wrap_ready", 64'(alu_ready), 1);
      tick();
      if (i > 1) begin
        check("wrap_aw", 64'(address_w), 64'(i - 1));
        check("wrap_dw", 64'(data_w),    64'(32'h100 + i - 1));
      end
    end
    alu_valid = 0;
    tick();
    check("wrap_last_aw", 64'(address_w), 6);
    tick(); tick();

    // Reset in the middle of activity discards everything.
    mem_valid = 1; mem_rd = 10; mem_data = 32'hB0;
    alu_valid = 1; alu_rd = 8; alu_data = 32'h80;
    tick();
    alu_rd = 9; alu_data = 32'h90;
    tick();
    idle_inputs();
    check("mid_full", 64'(alu_ready), 0);
    check("mid_aw",   64'(address_w), 10);
    reset = 1;
    tick();
    reset = 0;
    check("mid_rst_aw",   64'(address_w), 0);
    check("mid_rst_busy", 64'(busy),      0);
    for (int a = 8; a <= 10; a++) begin
      chk_addr = AW'(a);
      #1 check("mid_rst_hit", 64'(chk_hit), 0);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mid_no_stale", 64'(address_w == 8 || address_w == 9), 0);
    end

    // Random traffic with occasional resets, checked every cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 99) == 0);
      alu_valid = $urandom_range(0, 1);
      alu_rd    = AW'($urandom_range(0, 7));
      alu_data  = $urandom;
      mem_valid = ($urandom_range(0, 3) == 0);
      mem_rd    = AW'($urandom_range(0, 7));
      mem_data  = $urandom;
      chk_addr  = AW'($urandom_range(0, 7));
      tick();
    end
    reset = 0; idle_inputs();
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
